mem_bank: RTL and testbench

- Parametrised successor to the processor single-port program/data memory.
- Word array with byte-write strobes, a configurable registered read latency and a valid/ready request/response handshake with backpressure.
- Out-of-range and misaligned accesses return an error response.
- Sits between the core load/store unit (or fetch stage) and on-chip RAM; one request per cycle at full throughput.

---
 rtl/mem_bank.sv | 109 ++++++++++
 tb/tb_mem_bank.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank.sv
// mem_bank: single-port word memory with byte strobes, a LATENCY-stage response pipeline and
// valid/ready backpressure.
module mem_bank #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LATENCY   = 1,
  parameter string       INIT_FILE = "progMem.hex"
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iReqValid,
  output logic                oReqReady,
  input  logic                iReqWrite,
  input  logic [ADDR_W-1:0]   iAddr,
  input  logic [DATA_W-1:0]   iWData,
  input  logic [DATA_W/8-1:0] iWStrb,
  output logic                oRespValid,
  input  logic                iRespReady,
  output logic [DATA_W-1:0]   oRData,
  output logic                oRespErr,
  output logic                oRespWrite
);

  localparam int unsigned NUM_BYTES = DATA_W / 8;
  localparam int unsigned OFF       = $clog2(NUM_BYTES);
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef MEM_INIT_EN
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
`else
  logic [DATA_W-1:0] mem_q [DEPTH] = '{0: DATA_W'(55), default: '0};
`endif

  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_addr;
  logic              req_err;
  logic              stall;
  logic              accept;
  logic              wr_en;

  logic [LATENCY-1:0] stage_valid_q, stage_valid_d;
  logic [LATENCY-1:0] stage_write_q, stage_write_d;
  logic [LATENCY-1:0] stage_err_q, stage_err_d;
  logic [DATA_W-1:0]  stage_data_q [LATENCY];
  logic [DATA_W-1:0]  stage_data_d [LATENCY];

  assign word_idx = iAddr >> OFF;
  assign mem_addr = word_idx[IDX_W-1:0];
  assign req_err  = (iAddr[OFF-1:0] != '0) || (word_idx >= ADDR_W'(DEPTH));

  // A held response freezes the whole pipeline, bubbles included.
  assign stall     = stage_valid_q[LATENCY-1] & ~iRespReady;
  assign oReqReady = ~stall;
  assign accept    = iReqValid & oReqReady & ~iRst;
  assign wr_en     = accept & iReqWrite & ~req_err;

  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_write_d = stage_write_q;
    stage_err_d   = stage_err_q;
    stage_data_d  = stage_data_q;
    if (!stall) begin
      stage_valid_d[0] = accept;
      stage_write_d[0] = accept & iReqWrite;
      stage_err_d[0]   = accept & req_err;
      // Array is read before this edge's write lands; only reads of legal words carry data.
      stage_data_d[0]  = (accept & ~iReqWrite & ~req_err) ? mem_q[mem_addr] : '0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        stage_valid_d[i] = stage_valid_q[i-1];
        stage_write_d[i] = stage_write_q[i-1];
        stage_err_d[i]   = stage_err_q[i-1];
        stage_data_d[i]  = stage_data_q[i-1];
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stage_valid_q <= '0;
      stage_write_q <= '0;
      stage_err_q   <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage_data_q[i] <= '0;
      end
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_write_q <= stage_write_d;
      stage_err_q   <= stage_err_d;
      stage_data_q  <= stage_data_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (wr_en) begin
      for (int k = 0; k < int'(NUM_BYTES); k++) begin
        if (iWStrb[k]) begin
          mem_q[mem_addr][8*k +: 8] <= iWData[8*k +: 8];
        end
      end
    end
  end

  assign oRespValid = stage_valid_q[LATENCY-1];
  assign oRespWrite = stage_write_q[LATENCY-1];
  assign oRespErr   = stage_err_q[LATENCY-1];
  assign oRData     = stage_data_q[LATENCY-1];

endmodule

// File: tb/tb_mem_bank.sv
// tb_mem_bank: table-driven requests with a response scoreboard, plus backpressure and
// mid-flight reset sequences, on a LATENCY=3 mem_bank.
module tb_mem_bank;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] rdata;
  logic        resp_err;
  logic        resp_write;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cnt = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          exp_err;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] data;
    int          acc_edge;
    int          stall_at;
  } exp_t;

  exp_t sb[$];

  mem_bank #(
    .DATA_W (32),
    .DEPTH  (4096),
    .ADDR_W (32),
    .LATENCY(LAT)
  ) u_dut (
    .iClk      (clk),
    .iRst      (rst),
    .iReqValid (req_valid),
    .oReqReady (req_ready),
    .iReqWrite (req_write),
    .iAddr     (addr),
    .iWData    (wdata),
    .iWStrb    (wstrb),
    .oRespValid(resp_valid),
    .iRespReady(resp_ready),
    .oRData    (rdata),
    .oRespErr  (resp_err),
    .oRespWrite(resp_write)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input bit er, input logic [31:0] ed);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.strb = s; v.exp_err = er; v.exp_data = ed;
    return v;
  endfunction

  // Scoreboard pop; latency is only checked for responses that never saw a stall.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else if (resp_valid) begin
      if (!resp_ready) begin
        stall_cnt++;
      end else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got data %h expected no response", rdata);
      end else begin
        e = sb.pop_front();
        chk("resp_write", 64'(resp_write), 64'(e.wr));
        chk("resp_err", 64'(resp_err), 64'(e.err));
        chk("resp_data", 64'(rdata), 64'(e.data));
        if (e.stall_at == stall_cnt) chk("resp_latency", 64'(cyc), 64'(e.acc_edge + LAT - 1));
      end
    end
  end

  // Starts and ends just after a rising edge; holds the request until it is accepted.
  task automatic send(input vec_t v);
    int n = 0;
    bit done = 0;
    exp_t e;
    req_valid = 1'b1;
    req_write = v.wr;
    addr      = v.addr;
    wdata     = v.wdata;
    wstrb     = v.strb;
    while (!done) begin
      @(negedge clk);
      if (req_ready && !rst) begin
        e.wr = v.wr; e.err = v.exp_err; e.data = v.exp_data;
        e.acc_edge = cyc + 1; e.stall_at = stall_cnt;
        sb.push_back(e);
        done = 1;
      end else if (++n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept expected accept of addr %h", v.addr);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    vec_t tbl[$];
    int   n_bad;

    tbl.push_back(mk(1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 32'h0));
    tbl.push_back(mk(1, 32'h10,   32'h000000AA, 4'h1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h10,   32'h0,        4'h0, 0, 32'hDEADBEAA));
    tbl.push_back(mk(0, 32'h0,    32'h0,        4'h0, 0, 32'd55));
    tbl.push_back(mk(0, 32'h4,    32'h0,        4'h0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h8,    32'h0,        4'h0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h4000, 32'h0,        4'h0, 1, 32'h0));
    tbl.push_back(mk(1, 32'h2,    32'hFFFFFFFF, 4'hF, 1, 32'h0));
    tbl.push_back(mk(0, 32'h0,    32'h0,        4'h0, 0, 32'd55));
    tbl.push_back(mk(1, 32'h4000, 32'hFFFFFFFF, 4'hF, 1, 32'h0));
    tbl.push_back(mk(1, 32'h20,   32'h11223344, 4'h0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h20,   32'h0,        4'h0, 0, 32'h0));
    tbl.push_back(mk(1, 32'h20,   32'hA1B2C3D4, 4'hA, 0, 32'h0));
    tbl.push_back(mk(0, 32'h20,   32'h0,        4'h0, 0, 32'hA100C300));
    tbl.push_back(mk(1, 32'h3FFC, 32'h12345678, 4'hF, 0, 32'h0));
    tbl.push_back(mk(0, 32'h3FFC, 32'h0,        4'h0, 0, 32'h12345678));
    tbl.push_back(mk(0, 32'h4001, 32'h0,        4'h0, 1, 32'h0));
    tbl.push_back(mk(1, 32'h0,    32'h0000FF00, 4'h2, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,    32'h0,        4'h0, 0, 32'h0000FF37));
    tbl.push_back(mk(0, 32'h5,    32'h0,        4'h0, 1, 32'h0));

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_write", 64'(resp_write), 64'd0);
    @(posedge clk);
    #1;

    // Full-throughput table run
    for (int i = 0; i < tbl.size(); i++) send(tbl[i]);
    drain();

    // Backpressure: stall with a valid response, then release
    resp_ready = 1'b0;
    fork
      begin
        send(mk(0, 32'h10,   32'h0,        4'h0, 0, 32'hDEADBEAA));
        send(mk(1, 32'h24,   32'hCAFEF00D, 4'hF, 0, 32'h0));
        send(mk(0, 32'h24,   32'h0,        4'h0, 0, 32'hCAFEF00D));
        send(mk(0, 32'h3FFC, 32'h0,        4'h0, 0, 32'h12345678));
      end
      begin : bp_watch
        logic [33:0] snap;
        int          n;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 20) begin
          n++;
          @(negedge clk);
        end
        chk("bp_valid", 64'(resp_valid), 64'd1);
        snap = {resp_write, resp_err, rdata};
        for (int i = 0; i < 4; i++) begin
          if (i > 0) @(negedge clk);
          chk("bp_req_ready", 64'(req_ready), 64'd0);
          chk("bp_hold", 64'({resp_valid, resp_write, resp_err, rdata}), 64'({1'b1, snap}));
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
      end
    join
    drain();

    // Reset with two reads in flight; the write presented during reset must be ignored
    send(mk(0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEAA));
    send(mk(0, 32'h0,  32'h0, 4'h0, 0, 32'h0000FF37));
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; addr = 32'h10; wdata = 32'h0; wstrb = 4'hF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    n_bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) n_bad++;
    end
    chk("midrst_no_resp", 64'(n_bad), 64'd0);
    @(posedge clk);
    #1;
    send(mk(0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEAA));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
